lte_dl_ant_deframer: RTL and testbench
======================================

LTE_DL_ANT_DEFRAMER -- requirements
Module: lte_dl_ant_deframer

Interface
REQ-001 Parameter LOCK_CNT, default 3, is the number of consecutive correctly spaced i_ant8_sel markers needed to enter LOCK.
REQ-002 Parameter UNLOCK_CNT, default 2, is the number of consecutive bad boundaries in LOCK that force a return to HUNT.
REQ-003 Port clk_491p52, input, 1 bit, is the single clock; every register is on its rising edge.
REQ-004 Port rst_491p52, input, 1 bit, is the reset; it is synchronous and active-high.
REQ-005 Port i_fram_hd, input, 1 bit, is a one-cycle frame header pulse.
REQ-006 Port i_ant8_sel, input, 1 bit, marks word 0 of a 16-word antenna group.
REQ-007 Port i_data, input, 16 bits, is one half-sample word.
REQ-008 Port i_data_valid, input, 1 bit, qualifies i_data, i_ant8_sel and i_fram_hd.
REQ-009 Port o_fram_hd, output, 1 bit, is the frame header aligned to the output stream.
REQ-010 Port o_ant_idx, output, 3 bits, is the antenna index of o_iq.
REQ-011 Port o_iq, output, 32 bits, is the reassembled sample {I[15:0],Q[15:0]}.
REQ-012 Port o_iq_valid, output, 1 bit, qualifies o_iq and o_ant_idx.
REQ-013 Port o_sync_lock, output, 1 bit, is high while the state is LOCK.
REQ-014 Port o_align_err, output, 1 bit, is a one-cycle pulse on each bad boundary in LOCK.
REQ-015 Port o_err_cnt, output, 16 bits, counts o_align_err pulses and saturates at 16'hFFFF.

Function
REQ-016 Group format: 16 accepted words; word w (0..7) is I of antenna w, word w (8..15) is Q of antenna w-8.
REQ-017 Words are accepted only when i_data_valid=1; with i_data_valid=0, no counter, state or buffer changes, and i_ant8_sel and i_fram_hd are ignored.
REQ-018 The 4-bit word counter wcnt indexes the current accepted word; i_ant8_sel=1 on an accepted word forces that word to index 0, otherwise wcnt increments mod 16.
REQ-019 Boundary: an accepted word at the expected index 0 is good if i_ant8_sel=1 and bad if i_ant8_sel=0 (missing marker).
REQ-020 An i_ant8_sel=1 at an expected index other than 0 is bad (misplaced marker) and realigns wcnt to 0.
REQ-021 Words 0..7 are stored in an 8x16 I buffer.
REQ-022 On accepted word 8+k, o_iq={Ibuf[k],i_data} and o_ant_idx=k are registered, and o_iq_valid=1 the next cycle (latency 1), if state=LOCK and grp_ok=1.
REQ-023 grp_ok is set at word 0 when i_ant8_sel=1 and cleared at word 0 when i_ant8_sel=0.
REQ-024 FSM HUNT: the first accepted i_ant8_sel moves to CHECK with good_cnt=1.
REQ-025 FSM CHECK: a good boundary increments good_cnt and enters LOCK when good_cnt reaches LOCK_CNT.
REQ-026 FSM CHECK: a misplaced marker sets good_cnt=1 and stays in CHECK; a missing marker returns to HUNT.
REQ-027 FSM LOCK: a bad boundary, missing or misplaced, pulses o_align_err, increments o_err_cnt and increments miss_cnt; when miss_cnt reaches UNLOCK_CNT, the state goes to HUNT.
REQ-028 FSM LOCK: a good boundary clears miss_cnt.
REQ-029 Leaving LOCK suppresses o_iq_valid from the next accepted word onward.
REQ-030 An accepted i_fram_hd sets hd_pend; a second i_fram_hd while pending keeps a single pending flag.
REQ-031 o_fram_hd=1 on the first o_iq_valid with o_ant_idx=0 whose group word 0 was accepted at or after the i_fram_hd word; this emission clears hd_pend.
REQ-032 If i_fram_hd and i_ant8_sel arrive on the same word, that group carries the header.
REQ-033 An o_align_err pulse together with o_err_cnt=16'hFFFF leaves the count at 16'hFFFF.

Reset
REQ-034 While rst_491p52=1 at a clock edge, the state becomes HUNT and wcnt, good_cnt, miss_cnt, grp_ok and hd_pend become 0.
REQ-035 While rst_491p52=1 at a clock edge, all outputs become 0, including o_err_cnt; the I buffer is not reset.
REQ-036 A reset asserted mid-group discards the partial group; no o_iq_valid occurs until LOCK is re-acquired.

Verification
REQ-037 Scenario: continuous valid words with a marker every 16 words, I=16'h1000+k and Q=16'h2000+k -> o_sync_lock rises at the 3rd marker; the 4th group yields 8 outputs o_iq=32'h1000_2000+{k,k}, ant 0..7, each one cycle after its Q word.
REQ-038 Scenario: locked, then one marker moved to word 5 -> o_align_err pulses once, o_err_cnt=1, the lock holds, and the realigned group outputs normally.
REQ-039 Scenario: locked, then two consecutive markers dropped -> two o_align_err pulses and o_sync_lock=0 after the second, with no o_iq_valid during the missing groups.
REQ-040 Scenario: i_data_valid toggling 1010 under lock -> the outputs equal those of the continuous case, only stretched, with no spurious errors.
REQ-041 Scenario: i_fram_hd on word 3 of group N -> o_fram_hd is high with ant 0 of group N+1 only.
REQ-042 Scenario: reset asserted at word 10 of a locked group -> all outputs are 0 the next cycle, the state is HUNT, and lock re-acquires after 3 markers.

Source files
------------

// File: rtl/lte_dl_ant_deframer_if.sv
// Stream bundle for the downlink antenna deframer: word input side and
// reassembled IQ / sync-status output side.
interface lte_dl_ant_deframer_if;
    // Valid-only stream with no back-pressure. A word is taken on a rising edge
    // where i_data_valid=1, and i_data, i_ant8_sel and i_fram_hd are meaningful
    // only on that edge. o_iq_valid and o_align_err are single-cycle pulses.
    logic        i_fram_hd;
    logic        i_ant8_sel;
    logic [15:0] i_data;
    logic        i_data_valid;
    logic        o_fram_hd;
    logic [2:0]  o_ant_idx;
    logic [31:0] o_iq;
    logic        o_iq_valid;
    logic        o_sync_lock;
    logic        o_align_err;
    logic [15:0] o_err_cnt;

    modport master (
        output i_fram_hd, i_ant8_sel, i_data, i_data_valid,
        input  o_fram_hd, o_ant_idx, o_iq, o_iq_valid, o_sync_lock, o_align_err, o_err_cnt
    );

    modport slave (
        input  i_fram_hd, i_ant8_sel, i_data, i_data_valid,
        output o_fram_hd, o_ant_idx, o_iq, o_iq_valid, o_sync_lock, o_align_err, o_err_cnt
    );
endinterface

// File: rtl/lte_dl_ant_deframer.sv
// Deframes 16-word antenna groups (8 I words, then 8 Q words) into 32-bit IQ
// samples, with marker-based HUNT/CHECK/LOCK group synchronisation.
module lte_dl_ant_deframer #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2
) (
    input  logic                        clk_491p52,
    input  logic                        rst_491p52,
    lte_dl_ant_deframer_if.slave        bus,
    output logic [1:0]                  dbg_state
);
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_C   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_C = 8'(UNLOCK_CNT);

    state_t      state;
    logic [3:0]  wcnt;
    logic [7:0]  good_cnt;
    logic [7:0]  miss_cnt;
    logic        grp_ok;
    logic        hd_pend;
    logic        hd_grp;
    logic [15:0] ibuf [8];

    logic        acc;
    logic        sel;
    logic        at_zero;
    logic [3:0]  idx;
    logic        good_b;
    logic        miss_b;
    logic        mis_b;
    logic        emit;
    logic        emit_hd;

    // wcnt holds the index expected for the next accepted word.
    assign acc     = bus.i_data_valid;
    assign sel     = acc && bus.i_ant8_sel;
    assign at_zero = (wcnt == 4'd0);
    assign idx     = sel ? 4'd0 : wcnt;
    assign good_b  = acc && at_zero && sel;
    assign miss_b  = acc && at_zero && !sel;
    assign mis_b   = acc && !at_zero && sel;
    assign emit    = acc && idx[3] && (state == LOCK) && grp_ok;
    assign emit_hd = emit && (idx == 4'd8) && hd_grp;

    assign dbg_state = state;

    always_ff @(posedge clk_491p52) begin
        if (acc && !idx[3]) begin
            ibuf[idx[2:0]] <= bus.i_data;
        end
    end

    always_ff @(posedge clk_491p52) begin
        if (rst_491p52) begin
            state           <= HUNT;
            wcnt            <= 4'd0;
            good_cnt        <= 8'd0;
            miss_cnt        <= 8'd0;
            grp_ok          <= 1'b0;
            hd_pend         <= 1'b0;
            hd_grp          <= 1'b0;
            bus.o_fram_hd   <= 1'b0;
            bus.o_ant_idx   <= 3'd0;
            bus.o_iq        <= 32'd0;
            bus.o_iq_valid  <= 1'b0;
            bus.o_sync_lock <= 1'b0;
            bus.o_align_err <= 1'b0;
            bus.o_err_cnt   <= 16'd0;
        end else begin
            bus.o_iq_valid  <= 1'b0;
            bus.o_fram_hd   <= 1'b0;
            bus.o_align_err <= 1'b0;
            if (acc) begin
                wcnt    <= idx + 4'd1;
                hd_pend <= (hd_pend && !emit_hd) || bus.i_fram_hd;
                // A header seen up to and including word 0 belongs to this group.
                if (idx == 4'd0) begin
                    grp_ok <= sel;
                    hd_grp <= hd_pend || bus.i_fram_hd;
                end
                if (emit) begin
                    bus.o_iq_valid <= 1'b1;
                    bus.o_iq       <= {ibuf[idx[2:0]], bus.i_data};
                    bus.o_ant_idx  <= idx[2:0];
                    bus.o_fram_hd  <= emit_hd;
                end
                case (state)
                    HUNT: begin
                        if (sel) begin
                            good_cnt <= 8'd1;
                            miss_cnt <= 8'd0;
                            if (LOCK_C <= 8'd1) begin
                                state           <= LOCK;
                                bus.o_sync_lock <= 1'b1;
                            end else begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (good_b) begin
                            good_cnt <= good_cnt + 8'd1;
                            if (good_cnt + 8'd1 >= LOCK_C) begin
                                state           <= LOCK;
                                miss_cnt        <= 8'd0;
                                bus.o_sync_lock <= 1'b1;
                            end
                        end else if (mis_b) begin
                            good_cnt <= 8'd1;
                        end else if (miss_b) begin
                            state    <= HUNT;
                            good_cnt <= 8'd0;
                        end
                    end
                    LOCK: begin
                        if (good_b) begin
                            miss_cnt <= 8'd0;
                        end else if (miss_b || mis_b) begin
                            bus.o_align_err <= 1'b1;
                            if (bus.o_err_cnt != 16'hFFFF) begin
                                bus.o_err_cnt <= bus.o_err_cnt + 16'd1;
                            end
                            if (miss_cnt + 8'd1 >= UNLOCK_C) begin
                                state           <= HUNT;
                                good_cnt        <= 8'd0;
                                miss_cnt        <= 8'd0;
                                bus.o_sync_lock <= 1'b0;
                            end else begin
                                miss_cnt <= miss_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state           <= HUNT;
                        bus.o_sync_lock <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lte_dl_ant_deframer.sv
// Randomised scoreboard bench for lte_dl_ant_deframer: a group-level reference
// model predicts IQ samples, headers, alignment errors and lock status.
module tb_lte_dl_ant_deframer;
    localparam int LOCK_CNT   = 3;
    localparam int UNLOCK_CNT = 2;

    logic clk_491p52 = 1'b0;
    logic rst_491p52 = 1'b1;
    logic [1:0] dbg_state;
    int   cyc = 0;

    lte_dl_ant_deframer_if bus ();

    lte_dl_ant_deframer #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
        .clk_491p52 (clk_491p52),
        .rst_491p52 (rst_491p52),
        .bus        (bus),
        .dbg_state  (dbg_state)
    );

    always #2 clk_491p52 = ~clk_491p52;
    always @(posedge clk_491p52) cyc <= cyc + 1;

    // Scoreboard: {fram_hd, ant_idx, iq} plus the cycle each must appear in.
    logic [35:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [15:0] err_q[$];
    int          err_cyc_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          done   = 1'b0;

    // Reference model: sync phase (0 hunt, 1 check, 2 locked) and group position.
    int          m_phase;
    int          m_pos;
    int          m_good;
    int          m_miss;
    bit          m_grp_ok;
    bit          m_hd_pend;
    bit          m_hd_grp;
    int          m_err;
    logic [15:0] m_i [8];

    task automatic model_reset();
        m_phase   = 0;
        m_pos     = 0;
        m_good    = 0;
        m_miss    = 0;
        m_grp_ok  = 1'b0;
        m_hd_pend = 1'b0;
        m_hd_grp  = 1'b0;
        m_err     = 0;
    endtask

    task automatic model_word(input bit sel, input bit hd, input logic [15:0] d);
        int pos;
        bit good, missing, misplaced, out, hd_out;
        logic [2:0] ant;
        pos       = sel ? 0 : m_pos;
        good      = (m_pos == 0) && sel;
        missing   = (m_pos == 0) && !sel;
        misplaced = (m_pos != 0) && sel;
        out       = (pos >= 8) && (m_phase == 2) && m_grp_ok;
        hd_out    = out && (pos == 8) && m_hd_grp;
        if (out) begin
            ant = 3'(pos - 8);
            exp_q.push_back({hd_out, ant, m_i[pos - 8], d});
            exp_cyc_q.push_back(cyc + 1);
        end
        if (pos < 8) m_i[pos] = d;
        m_hd_pend = (m_hd_pend && !hd_out) || hd;
        if (pos == 0) begin
            m_grp_ok = sel;
            m_hd_grp = m_hd_pend;
        end
        case (m_phase)
            0: if (sel) begin
                m_good  = 1;
                m_miss  = 0;
                m_phase = (LOCK_CNT <= 1) ? 2 : 1;
            end
            1: if (good) begin
                m_good = m_good + 1;
                if (m_good >= LOCK_CNT) begin
                    m_phase = 2;
                    m_miss  = 0;
                end
            end else if (misplaced) begin
                m_good = 1;
            end else if (missing) begin
                m_phase = 0;
                m_good  = 0;
            end
            default: if (good) begin
                m_miss = 0;
            end else if (missing || misplaced) begin
                if (m_err < 65535) m_err = m_err + 1;
                err_q.push_back(16'(m_err));
                err_cyc_q.push_back(cyc + 1);
                m_miss = m_miss + 1;
                if (m_miss >= UNLOCK_CNT) begin
                    m_phase = 0;
                    m_good  = 0;
                    m_miss  = 0;
                end
            end
        endcase
        m_pos = (pos + 1) % 16;
    endtask

    task automatic drive(input bit v, input bit sel, input bit hd, input logic [15:0] d);
        @(negedge clk_491p52);
        rst_491p52       = 1'b0;
        bus.i_data_valid = v;
        bus.i_ant8_sel   = sel;
        bus.i_fram_hd    = hd;
        bus.i_data       = d;
        if (v) model_word(sel, hd, d);
    endtask

    // Idle cycles carry random marker/header/data that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_491p52);
            rst_491p52       = 1'b1;
            bus.i_data_valid = 1'($urandom_range(0, 1));
            bus.i_ant8_sel   = 1'($urandom_range(0, 1));
            bus.i_fram_hd    = 1'($urandom_range(0, 1));
            bus.i_data       = 16'($urandom);
            model_reset();
        end
    endtask

    // gap: 0 continuous, 1 alternate valid, 2 random idle gaps.
    task automatic send_group(input int n, input bit mark, input int hd_pos,
                              input bit rnd, input int gap);
        logic [15:0] d;
        for (int w = 0; w < n; w++) begin
            if (gap == 1) idle(1);
            else if (gap == 2) idle($urandom_range(0, 2));
            if (rnd) d = 16'($urandom);
            else if (w < 8) d = 16'h1000 + 16'(w);
            else d = 16'h2000 + 16'(w - 8);
            drive(1'b1, mark && (w == 0), w == hd_pos, d);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk_491p52);
            #1;
            if (rst_491p52) begin
                checks++;
                if (bus.o_iq_valid !== 1'b0 || bus.o_fram_hd !== 1'b0 || bus.o_iq !== 32'd0 ||
                    bus.o_ant_idx !== 3'd0 || bus.o_sync_lock !== 1'b0 ||
                    bus.o_align_err !== 1'b0 || bus.o_err_cnt !== 16'd0 || dbg_state !== 2'd0) begin
                    errors++;
                    $display("FAIL reset_state: got valid=%b hd=%b iq=%h ant=%0d lock=%b aerr=%b ecnt=%0d st=%0d, need all 0",
                             bus.o_iq_valid, bus.o_fram_hd, bus.o_iq, bus.o_ant_idx, bus.o_sync_lock,
                             bus.o_align_err, bus.o_err_cnt, dbg_state);
                end
            end
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL iq_missing: got no o_iq_valid at cycle %0d, need %h", exp_cyc_q[0], exp_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (bus.o_iq_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL iq_spurious: got valid iq=%h ant=%0d at cycle %0d, need none",
                             bus.o_iq, bus.o_ant_idx, cyc);
                end else begin
                    if ({bus.o_fram_hd, bus.o_ant_idx, bus.o_iq} !== exp_q[0] || exp_cyc_q[0] != cyc) begin
                        errors++;
                        $display("FAIL iq_data: got hd/ant/iq=%h at cycle %0d, need %h at cycle %0d",
                                 {bus.o_fram_hd, bus.o_ant_idx, bus.o_iq}, cyc, exp_q[0], exp_cyc_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end else if (bus.o_fram_hd !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL fram_hd_alone: got o_fram_hd=%b without o_iq_valid, need 0", bus.o_fram_hd);
            end
            if (err_cyc_q.size() > 0 && err_cyc_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL align_err_missing: got no pulse at cycle %0d, need one", err_cyc_q[0]);
                void'(err_q.pop_front());
                void'(err_cyc_q.pop_front());
            end
            if (bus.o_align_err === 1'b1) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL align_err_spurious: got pulse at cycle %0d, need none", cyc);
                end else begin
                    if (bus.o_err_cnt !== err_q[0] || err_cyc_q[0] != cyc) begin
                        errors++;
                        $display("FAIL align_err_cnt: got cnt=%0d at cycle %0d, need %0d at cycle %0d",
                                 bus.o_err_cnt, cyc, err_q[0], err_cyc_q[0]);
                    end
                    void'(err_q.pop_front());
                    void'(err_cyc_q.pop_front());
                end
            end
            checks++;
            if (bus.o_sync_lock !== (m_phase == 2) || bus.o_err_cnt !== 16'(m_err)) begin
                errors++;
                $display("FAIL lock_status: got lock=%b err_cnt=%0d at cycle %0d, need lock=%b err_cnt=%0d",
                         bus.o_sync_lock, bus.o_err_cnt, cyc, (m_phase == 2), m_err);
            end
            if (done) begin
                checks++;
                if (exp_q.size() != 0 || err_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: got %0d iq and %0d err expectations left, need 0",
                             exp_q.size(), err_q.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_data_valid = 1'b0;
        bus.i_ant8_sel   = 1'b0;
        bus.i_fram_hd    = 1'b0;
        bus.i_data       = 16'd0;
        model_reset();
        do_reset(3);
        idle(2);

        // Clean acquisition: lock on the 3rd marker, then steady groups.
        for (int g = 0; g < 5; g++) send_group(16, 1'b1, -1, 1'b0, 0);
        // Header on word 3 of a group: carried by the following group.
        send_group(16, 1'b1, 3, 1'b0, 0);
        for (int g = 0; g < 2; g++) send_group(16, 1'b1, -1, 1'b0, 0);
        // Marker moved to word 5: one misplaced error, lock holds.
        send_group(5, 1'b1, -1, 1'b0, 0);
        for (int g = 0; g < 3; g++) send_group(16, 1'b1, -1, 1'b0, 0);
        // Valid toggling 1010 under lock.
        for (int g = 0; g < 3; g++) send_group(16, 1'b1, -1, 1'b0, 1);
        // Header on the marker word itself.
        send_group(16, 1'b1, 0, 1'b1, 0);
        send_group(16, 1'b1, -1, 1'b1, 0);
        // Two dropped markers: unlock, then re-acquire.
        send_group(16, 1'b0, -1, 1'b0, 0);
        send_group(16, 1'b0, -1, 1'b0, 0);
        for (int g = 0; g < 4; g++) send_group(16, 1'b1, -1, 1'b0, 0);
        // Randomised traffic with gaps, headers, short and unmarked groups.
        for (int g = 0; g < 60; g++) begin
            send_group(($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16,
                       $urandom_range(0, 7) != 0,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1,
                       1'b1, 2);
        end
        for (int g = 0; g < 4; g++) send_group(16, 1'b1, -1, 1'b1, 0);
        // Reset at word 10 of a locked group, then re-acquire.
        send_group(10, 1'b1, -1, 1'b0, 0);
        do_reset(1);
        for (int g = 0; g < 4; g++) send_group(16, 1'b1, -1, 1'b0, 0);
        idle(4);
        @(negedge clk_491p52);
        done = 1'b1;
    end
endmodule
